// File: rtl/snd_pkg.sv
// snd_pkg: shared state encoding and defaults for the sound scheduler
package snd_pkg;
  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_PLAY, S_GAP} state_t;
  localparam logic [5:0] IDLE_SEL_DEF = 6'b111111;
  localparam int CNT_W_DEF = 24;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin over requesters 1..N_REQ-1 starting at ptr
//   req : request bits 1..N_REQ-1
//   ptr : first index to consider (1..N_REQ-1)
//   gnt : one-hot grant, idx : granted index (0 when nothing requests)
module rr_arbiter
  import snd_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int OW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:1] req,
  input  logic [OW-1:0]    ptr,
  output logic [N_REQ-1:1] gnt,
  output logic [OW-1:0]    idx
);
  logic [OW-1:0] c;
  always_comb begin
    gnt = '0;
    idx = '0;
    c = '0;
    for (int k = 0; k < N_REQ - 1; k++) begin
      c = OW'((int'(ptr) - 1 + k) % (N_REQ - 1) + 1);
      if (gnt == '0 && req[c]) begin
        gnt[c] = 1'b1;
        idx = c;
      end
    end
  end
endmodule

// File: rtl/sound_sched.sv
// sound_sched: arbitrates requesters onto one sound player and sequences pulse/hold/gap
//   PCLK, PRESERN     : clock, async active-low reset
//   enable            : global enable; low mutes and blocks grants
//   req, req_sel      : request levels and per-requester selection codes
//   ack, done         : one-cycle grant and normal-completion pulses
//   selection         : code to player, sound_reset : trigger to player
//   busy, owner       : activity flag and current/last granted requester
module sound_sched
  import snd_pkg::*;
#(
  parameter int             N_REQ     = 4,
  parameter int             SEL_W     = 6,
  parameter logic [SEL_W-1:0] IDLE_SEL = IDLE_SEL_DEF,
  parameter int             CNT_W     = CNT_W_DEF,
  parameter int             PULSE_CYC = 16,
  parameter int             HOLD_CYC  = 2500000,
  parameter int             GAP_CYC   = 4
) (
  input  logic                     PCLK,
  input  logic                     PRESERN,
  input  logic                     enable,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*SEL_W-1:0]   req_sel,
  output logic [N_REQ-1:0]         ack,
  output logic [N_REQ-1:0]         done,
  output logic [SEL_W-1:0]         selection,
  output logic                     sound_reset,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] owner
);
  localparam int OW = $clog2(N_REQ);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [SEL_W-1:0] code, code_nx, sel_nx;
  logic [OW-1:0] owner_nx, ptr, ptr_nx, arb_idx, win;
  logic [N_REQ-1:1] arb_gnt;
  logic [N_REQ-1:0] ack_nx, done_nx;
  logic grant, running;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req(req[N_REQ-1:1]),
    .ptr(ptr),
    .gnt(arb_gnt),
    .idx(arb_idx)
  );

  assign busy = state != S_IDLE;
  assign running = state == S_PULSE || state == S_PLAY;
  assign win = req[0] ? '0 : arb_idx;
  // Requester 0 may cut into PLAY/GAP of another owner; everyone else waits for IDLE.
  assign grant = enable && (state == S_IDLE ? |req
                 : (state == S_PLAY || state == S_GAP) && req[0] && owner != '0);

  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    code_nx = code;
    owner_nx = owner;
    ptr_nx = ptr;
    ack_nx = '0;
    done_nx = '0;
    if (grant) begin
      state_nx = S_PULSE;
      cnt_nx = CNT_W'(PULSE_CYC - 1);
      code_nx = req_sel[int'(win)*SEL_W +: SEL_W];
      owner_nx = win;
      ack_nx = req[0] ? N_REQ'(1) : {arb_gnt, 1'b0};
      ptr_nx = req[0] ? ptr : arb_idx == OW'(N_REQ - 1) ? OW'(1) : arb_idx + 1'b1;
    end else if (!enable && running) begin
      state_nx = S_GAP;
      cnt_nx = CNT_W'(GAP_CYC - 1);
    end else if (state != S_IDLE) begin
      cnt_nx = cnt - 1'b1;
      if (cnt == '0) begin
        state_nx = state == S_PULSE ? S_PLAY : state == S_PLAY ? S_GAP : S_IDLE;
        cnt_nx = state == S_PULSE ? CNT_W'(HOLD_CYC - 1) : state == S_PLAY ? CNT_W'(GAP_CYC - 1) : '0;
        done_nx = state == S_PLAY ? N_REQ'(1) << owner : '0;
      end
    end
    sel_nx = (state_nx == S_PULSE || state_nx == S_PLAY) ? code_nx : IDLE_SEL;
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state <= S_IDLE;
      cnt <= '0;
      code <= IDLE_SEL;
      owner <= '0;
      ptr <= OW'(1);
      ack <= '0;
      done <= '0;
      selection <= IDLE_SEL;
      sound_reset <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      code <= code_nx;
      owner <= owner_nx;
      ptr <= ptr_nx;
      ack <= ack_nx;
      done <= done_nx;
      selection <= sel_nx;
      sound_reset <= state_nx == S_PULSE;
    end
  end
endmodule

// File: doc/sound_sched.md
Name: sound_sched

Overview:
- Scheduler for the single shared sound-player resource, driven by the `selection[5:0]` and `reset` lines.
- Arbitrates N_REQ hardware requesters (game events, APB shadow register, music sequencer) and grants one at a time.
- Per grant, sequences the player: trigger pulse, then hold, then silence gap.
- Requester 0 is the high-priority channel (miss/alarm) and may preempt a playing sound. All other requesters share round-robin.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- SEL_W, 6, sound selection width.
- IDLE_SEL, 6'b111111, selection code meaning silence.
- CNT_W, 24, width of the phase counter.
- PULSE_CYC, 16, PCLK cycles sound_reset is held high per trigger (>=1).
- HOLD_CYC, 2500000, PCLK cycles the selection is held after the pulse (>=1).
- GAP_CYC, 4, PCLK cycles of IDLE_SEL between sounds (>=1).

Ports:
- PCLK  in  1  system clock.
- PRESERN  in  1  reset, asynchronous, active-low.
- enable  in  1  global sound enable; low = mute/stop.
- req  in  N_REQ  request level per requester; held until ack.
- req_sel  in  N_REQ*SEL_W  selection code per requester; slice i = [i*SEL_W +: SEL_W]; stable while req[i] is high.
- ack  out  N_REQ  one-cycle grant pulse, registered.
- done  out  N_REQ  one-cycle pulse when the owner's sound completes its HOLD phase normally.
- selection  out  SEL_W  to the sound player; registered.
- sound_reset  out  1  to the sound player; registered.
- busy  out  1  state != IDLE.
- owner  out  $clog2(N_REQ)  index of the current/last granted requester.

Behaviour:
- Reset (async, PRESERN low): state=IDLE, selection=IDLE_SEL, sound_reset=0, ack=0, done=0, busy=0, owner=0, counter=0, rr pointer=1.
- Release is synchronous to PCLK.
- States: IDLE, PULSE, PLAY, GAP. All outputs are registered and reflect the current state.
- IDLE: selection=IDLE_SEL, sound_reset=0.
  - If enable & |req at edge t: grant winner w, latch req_sel[w], set owner=w, counter=PULSE_CYC-1, ack[w]=1 for cycle t+1, go to PULSE.
- Arbitration:
  - req[0] always wins.
  - Otherwise round-robin over 1..N_REQ-1, starting at the rr pointer.
  - The pointer moves to w+1 (wrapping N_REQ-1 -> 1) only on a grant to w>=1.
- PULSE: selection=latched code, sound_reset=1. Counter decrements; at 0 load HOLD_CYC-1 and go to PLAY.
- PLAY: selection=latched code, sound_reset=0. Counter at 0: done[owner]=1 next cycle, load GAP_CYC-1, go to GAP.
- GAP: selection=IDLE_SEL, sound_reset=0. Counter at 0: go to IDLE.
- Preemption:
  - In PLAY or GAP with req[0] & enable & owner!=0: grant 0 exactly as in IDLE (ack[0], latch, PULSE). No GAP is inserted.
  - The preempted owner gets no done.
  - req[0] while owner==0 waits for IDLE.
- enable low in PULSE or PLAY: next state is GAP (counter=GAP_CYC-1); no done. No grants occur while enable is low.
- Simultaneous PLAY-counter-0 and req[0] preempt: preempt wins; no done.
- Timing for a grant at edge t (ack high in cycle t+1):
  - sound_reset high in cycles t+1..t+PULSE_CYC.
  - done at cycle t+PULSE_CYC+HOLD_CYC+1.
  - Earliest next ack at t+PULSE_CYC+HOLD_CYC+GAP_CYC+2.
- Requests never stall combinationally. A requester that drops req before ack is simply not granted.
- ack and done are never high for more than one cycle per grant. At most one ack bit is set at a time.

Decomposition:
- Package snd_pkg:
  - state encoding (IDLE/PULSE/PLAY/GAP, 2 bits)
  - IDLE_SEL default
  - CNT_W
- Sub-module rr_arbiter: N-1-way round-robin with pointer input, grant one-hot and index outputs; purely combinational. sound_sched owns the pointer register.

Test Plan (N_REQ=4, PULSE_CYC=2, HOLD_CYC=5, GAP_CYC=3):
- Reset: PRESERN low mid-PLAY -> same cycle selection=6'h3F, sound_reset=0, busy=0, ack=0. After release, idle until req.
- Single request: req[2]=1, req_sel[2]=6'h05 at edge t -> ack[2] at t+1; sound_reset=1 at t+1..t+2; selection=6'h05 t+1..t+7; done[2] at t+8; selection=6'h3F t+8..t+10.
- Round-robin: req[1], req[2], req[3] held continuously -> grants ordered 1,2,3,1, with ack spacing 11 cycles.
- Preempt: req[3]=6'h09 playing; assert req[0]=6'h01 in PLAY -> ack[0] next cycle, selection=6'h01, sound_reset=1 for 2 cycles, no done[3], done[0] after 7 more cycles.
- Priority at IDLE: req[0] and req[1] asserted the same cycle -> ack[0] first; req[1] granted after req[0]'s gap completes.
- Mute: enable dropped in PULSE -> next cycle GAP, selection=6'h3F, no done. With enable low and req[1] high, no ack ever occurs.
